// File: rtl/sha_display_pkg.sv
// Shared constants, FSM state type and nibble-index helper for the SHA-256 digest display.
package sha_display_pkg;

  localparam int DIGEST_W = 256;
  localparam int NIBBLES  = 64;

  typedef enum logic {
    ST_IDLE,
    ST_SHOW
  } state_t;

  // Digit 0 is the rightmost digit, so the nibble order is reversed within a page.
  function automatic logic [5:0] nibble_index(input int pg, input int dg, input int num_digits);
    return 6'(pg * num_digits + (num_digits - 1 - dg));
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Modulo-DIV prescaler producing a one-cycle tick on the terminal count.
module refresh_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(DIV - 1));
  assign tick   = at_end && !restart;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digest_display_scanner.sv
// Captures a SHA-256 digest and scans its 64 nibbles page by page over a common-anode digit bank.
// Optional AUTO_PAGE_EN adds a page-hold counter that advances the page every PAGE_CYCLES cycles.
module digest_display_scanner #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_DIV = 100000,
  parameter  int PAGE_CYCLES = 200000000,
  localparam int NUM_PAGES   = 64 / NUM_DIGITS,
  localparam int PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int DIGIT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  digest_valid,
  input  logic [255:0]          digest,
  input  logic                  next_page,
  input  logic                  clear,
  output logic [3:0]            nibble,
  output logic                  rounds_done,
  output logic [NUM_DIGITS-1:0] an,
  output logic [PAGE_W-1:0]     page
);

  import sha_display_pkg::*;

  state_t                state_q, state_d;
  logic [PAGE_W-1:0]     page_q, page_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [DIGEST_W-1:0]   digest_q, digest_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  rounds_done_q, rounds_done_d;

  logic                  refresh_restart;
  logic                  refresh_tick;
  logic                  page_tick;
  logic [5:0]            nib_idx;
  logic [7:0]            bit_hi;

  assign refresh_restart = clear | digest_valid | (state_q != ST_SHOW);

  refresh_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_refresh (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (refresh_restart),
    .tick    (refresh_tick)
  );

`ifdef AUTO_PAGE_EN
  logic hold_restart;

  // A manual step restarts the hold interval as well as a capture or clear.
  assign hold_restart = clear | digest_valid | next_page | (state_q != ST_SHOW);

  refresh_tick_gen #(
    .DIV (PAGE_CYCLES)
  ) u_page_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (hold_restart),
    .tick    (page_tick)
  );
`else
  logic unused_page_cycles;

  assign unused_page_cycles = (PAGE_CYCLES != 0);
  assign page_tick          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    digit_d  = digit_q;
    digest_d = digest_q;

    if (clear) begin
      state_d  = ST_IDLE;
      page_d   = '0;
      digit_d  = '0;
      digest_d = '0;
    end else if (digest_valid) begin
      state_d  = ST_SHOW;
      page_d   = '0;
      digit_d  = '0;
      digest_d = digest;
    end else if (state_q == ST_SHOW) begin
      if (next_page || page_tick) begin
        page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
      end
      if (refresh_tick) begin
        digit_d = (digit_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
      end
    end
  end

  // Outputs are derived from next-state values so anode and nibble always update together.
  always_comb begin
    nib_idx       = nibble_index(int'(page_d), int'(digit_d), NUM_DIGITS);
    bit_hi        = 8'(DIGEST_W - 1 - 4 * int'(nib_idx));
    an_d          = '1;
    nibble_d      = 4'h0;
    rounds_done_d = 1'b0;
    if (state_d == ST_SHOW) begin
      an_d[digit_d] = 1'b0;
      nibble_d      = digest_d[bit_hi -: 4];
      rounds_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      page_q        <= '0;
      digit_q       <= '0;
      digest_q      <= '0;
      an_q          <= '1;
      nibble_q      <= 4'h0;
      rounds_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      page_q        <= page_d;
      digit_q       <= digit_d;
      digest_q      <= digest_d;
      an_q          <= an_d;
      nibble_q      <= nibble_d;
      rounds_done_q <= rounds_done_d;
    end
  end

  assign an          = an_q;
  assign nibble      = nibble_q;
  assign rounds_done = rounds_done_q;
  assign page        = page_q;

endmodule

// File: doc/digest_display_scanner.md
# digest_display_scanner

Time-multiplexed display controller for the SHA-256 result. It captures the 256-bit digest when the hash core signals completion and splits it into 64 hex nibbles. It scans those nibbles page by page across a bank of common-anode digits, driving the existing hex-to-segment decoder's `value` and `rounds_done` inputs plus the digit anode enables.

## Interface
- `NUM_DIGITS`, default 8: physical digits per page. Legal values are 1, 2, 4, 8. Page count `NUM_PAGES` = 64/`NUM_DIGITS`.
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit. Must be ≥ 2.
- `PAGE_CYCLES`, default 200000000: cycles per page in auto-advance mode. Used only with `AUTO_PAGE_EN`.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `digest_valid`, input, 1: single-cycle pulse; `digest` is valid in the same cycle.
- `digest`, input, 256: hash result, bit 255 = MSB of H0.
- `next_page`, input, 1: single-cycle pulse, already synchronised and debounced upstream.
- `clear`, input, 1: single-cycle pulse; blank the display and drop the stored digest.
- `nibble`, output, 4: hex value for the decoder's `value` input.
- `rounds_done`, output, 1: decoder enable; 1 while a digest is held.
- `an`, output, `NUM_DIGITS`: active-low digit enables, one-hot-low while showing.
- `page`, output, log2(`NUM_PAGES`) (min 1): current page index.

## Operation
- FSM states:
  - IDLE: `rounds_done`=0, `an` all ones, `nibble`=0.
  - SHOW: scanning.
- Transitions:
  - IDLE→SHOW on `digest_valid`.
  - SHOW→SHOW on `digest_valid`: re-capture, reset `page`, `digit` and the refresh counter to 0.
  - Any state→IDLE on `clear`.
- Priority when pulses coincide: `clear` > `digest_valid` > `next_page`.
- `digit` counts 0…`NUM_DIGITS`-1 and wraps to 0. `an[digit]`=0 and all other bits are 1. Digit 0 is the rightmost digit.
- Nibble mapping, MSB-first reading left to right:
  - k = `page`·`NUM_DIGITS` + (`NUM_DIGITS`-1-`digit`).
  - `nibble` = digest_reg[255-4k -: 4].
  - Page 0 leftmost digit therefore shows digest[255:252].
- `next_page` in SHOW increments `page`, wrapping `NUM_PAGES`-1 → 0. It does not reset `digit` or the refresh counter. It is ignored in IDLE.
- The digest register holds its value until the next `digest_valid`. In IDLE its contents are don't-care.

## Timing
- Reset values: state=IDLE, `an`=all ones, `nibble`=0, `rounds_done`=0, `page`=0, `digit`=0, refresh counter=0, digest_reg=0.
- `an`, `nibble` and `rounds_done` are registered and change on the same edge. There is never a cycle where `an` selects a digit whose `nibble` is stale.
- Latency: with `digest_valid` high in cycle t, cycle t+1 shows `rounds_done`=1, `an`=~1 and `nibble` = digest[255-4(`NUM_DIGITS`-1) -: 4].
- Refresh counter runs 0…`REFRESH_DIV`-1. On the terminal count, `digit` advances at the next edge, so each digit is lit for exactly `REFRESH_DIV` cycles.
- `next_page` in cycle t gives the new page's nibble at t+1.
- `clear` in cycle t gives `an` all ones and `rounds_done`=0 at t+1.
- Asserting reset mid-scan returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- `AUTO_PAGE_EN` defined:
  - Adds a page-hold counter that runs only in SHOW.
  - Every `PAGE_CYCLES` cycles `page` advances and wraps.
  - The counter resets to 0 on `digest_valid`, `clear` or `next_page`, so a manual step restarts the hold interval.
- `AUTO_PAGE_EN` undefined: there is no page-hold counter, and `page` changes only on `next_page` or capture.

## Structure
- Package `sha_display_pkg` holds:
  - `DIGEST_W`=256 and `NIBBLES`=64.
  - The FSM state typedef {`ST_IDLE`, `ST_SHOW`}.
  - The nibble-index helper function.
- Sub-module `refresh_tick_gen`: modulo-N prescaler with one parameter `DIV`, `clk`/`rst_n` inputs, a synchronous `restart` input and a one-cycle `tick` output. It is instantiated once for the digit refresh, and once more for the page hold under `AUTO_PAGE_EN`.

## Test plan
All scenarios use `REFRESH_DIV`=4 and `NUM_DIGITS`=8.
- Reset, then run 20 cycles with no stimulus → `an`=8'hFF, `rounds_done`=0, `nibble`=0 throughout.
- `digest_valid` with digest=256'h0123456789ABCDEF…(repeating) → cycle t+1: `an`=8'hFE, `nibble`=4'h7. After 4 cycles: `an`=8'hFD, `nibble`=4'h6. After 32 cycles: back to 8'hFE.
- Issue 7 `next_page` pulses → `page`=7, digit 0 shows digest[3:0]. An 8th pulse → `page`=0.
- Assert `clear` and `digest_valid` in the same cycle → next cycle IDLE, `an`=8'hFF, `rounds_done`=0.
- Assert `digest_valid` and `next_page` in the same cycle while on page 5 → `page`=0, `digit`=0, new digest shown.
- Drop `rst_n` mid-scan with no clock edge → outputs reach reset values within the same cycle. With `AUTO_PAGE_EN` and `PAGE_CYCLES`=10, `page` increments every 10 cycles in SHOW.
